alu_ga_stim_gen: RTL

Hardware stimulus generator for the ALU verification environment: turns a genetic-algorithm chromosome (cumulative weight tables for opcode, operand ranges and inter-transaction delay) into a constrained-random stream of ALU input transactions. Runs in the accelerated (FPGA) path in place of the software sequence, feeding the ALU driver through a valid/ready stream. It generalises the software chromosome to arbitrary data width, opcode count and delay range, and adds per-run seeding and transaction counting.

---
 rtl/alu_ga_pkg.sv | 52 +++++
 rtl/ga_weighted_select.sv | 33 +++
 rtl/alu_ga_stim_gen.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ga_pkg.sv
// -----------------------------------------------------------------------------
// alu_ga_pkg
// Shared definitions for the GA-driven ALU stimulus generator.
//   - state_e      : generator FSM states
//   - LFSR_POLY    : Galois tap mask shared by both LFSRs
//   - BIN_*        : operand-shaping bin encodings
//   - *_base()     : chromosome table address offsets, derived from opcode count
//   - lfsr_next()  : one Galois LFSR step
//   - lfsr_seed()  : seed sanitiser (an all-zero LFSR would lock up)
// -----------------------------------------------------------------------------
package alu_ga_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_HOLD,
        ST_DELAY,
        ST_DONE
    } state_e;

    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
    localparam int          THR_WIDTH    = 8;
    localparam int          OPERAND_BINS = 4;

    localparam logic [1:0] BIN_ZERO   = 2'd0;
    localparam logic [1:0] BIN_SMALL  = 2'd1;
    localparam logic [1:0] BIN_RANDOM = 2'd2;
    localparam logic [1:0] BIN_ONES   = 2'd3;

    // Table layout: opcode weights first, then op-A bins, op-B bins, delay bins.
    function automatic int op_a_base(input int num_ops);
        return num_ops;
    endfunction

    function automatic int op_b_base(input int num_ops);
        return num_ops + OPERAND_BINS;
    endfunction

    function automatic int delay_base(input int num_ops);
        return num_ops + 2 * OPERAND_BINS;
    endfunction

    // Right-shifting Galois form: the bit shifted out selects the tap mask.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

endpackage

// File: rtl/ga_weighted_select.sv
// -----------------------------------------------------------------------------
// ga_weighted_select
// Maps an 8-bit random value onto a cumulative threshold table: the result is
// the smallest index whose threshold is strictly greater than r, or the last
// index when no threshold qualifies.
// Ports:
//   thr : ENTRIES packed 8-bit thresholds, entry i at thr[i*8 +: 8]
//   r   : 8-bit random value
//   idx : selected entry index
// -----------------------------------------------------------------------------
module ga_weighted_select
    import alu_ga_pkg::*;
#(
    parameter  int ENTRIES = 4,
    localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic [ENTRIES*THR_WIDTH-1:0] thr,
    input  logic [THR_WIDTH-1:0]         r,
    output logic [IDX_W-1:0]             idx
);

    // Scanning from the top down lets the lowest qualifying index overwrite
    // any higher one, which gives the "smallest i" priority directly.
    always_comb begin
        idx = IDX_W'(ENTRIES - 1);
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r < thr[i*THR_WIDTH +: THR_WIDTH]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_ga_stim_gen.sv
// -----------------------------------------------------------------------------
// alu_ga_stim_gen
// Turns a GA chromosome (cumulative weight tables for opcode, operand bins and
// inter-transaction delay) into a constrained-random stream of ALU transactions
// on a valid/ready interface.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   cfg_we/addr/data     : chromosome table write port (accepted only when idle)
//   start, seed,
//   trans_num            : run launch; seed and length sampled on start
//   out_valid/ready      : transaction handshake
//   out_op, out_a, out_b : transaction fields, stable while out_valid is high
//   busy, done           : run in progress / one-cycle end-of-run pulse
//   sent_cnt             : transactions accepted in the current/last run
// -----------------------------------------------------------------------------
module alu_ga_stim_gen
    import alu_ga_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 4,
    parameter int DELAY_BINS = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [7:0]            cfg_addr,
    input  logic [7:0]            cfg_data,
    input  logic                  start,
    input  logic [31:0]           seed,
    input  logic [CNT_WIDTH-1:0]  trans_num,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OP_WIDTH-1:0]   out_op,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  sent_cnt
);

    localparam int NUM_OPS = 2 ** OP_WIDTH;
    localparam int DLY_W   = (DELAY_BINS > 1) ? $clog2(DELAY_BINS) : 1;
    localparam int A_BASE  = op_a_base(NUM_OPS);
    localparam int B_BASE  = op_b_base(NUM_OPS);
    localparam int D_BASE  = delay_base(NUM_OPS);

    state_e                          state_q, state_d;
    logic [NUM_OPS*THR_WIDTH-1:0]    op_thr_q, op_thr_d;
    logic [OPERAND_BINS*THR_WIDTH-1:0] a_thr_q, a_thr_d;
    logic [OPERAND_BINS*THR_WIDTH-1:0] b_thr_q, b_thr_d;
    logic [DELAY_BINS*THR_WIDTH-1:0] dly_thr_q, dly_thr_d;
    logic [31:0]                     lfsr_a_q, lfsr_a_d;
    logic [31:0]                     lfsr_b_q, lfsr_b_d;
    logic [CNT_WIDTH-1:0]            trans_num_q, trans_num_d;
    logic [CNT_WIDTH-1:0]            sent_cnt_q, sent_cnt_d;
    logic [DLY_W-1:0]                dly_q, dly_d;
    logic [DLY_W-1:0]                dly_cnt_q, dly_cnt_d;
    logic [OP_WIDTH-1:0]             out_op_q, out_op_d;
    logic [DATA_WIDTH-1:0]           out_a_q, out_a_d;
    logic [DATA_WIDTH-1:0]           out_b_q, out_b_d;
    logic                            out_valid_q, out_valid_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;

    logic [OP_WIDTH-1:0]   sel_op;
    logic [1:0]            sel_a;
    logic [1:0]            sel_b;
    logic [DLY_W-1:0]      sel_dly;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] data_b;
    logic [CNT_WIDTH-1:0]  sent_cnt_inc;

    // Each LFSR-A byte drives one independent weighted choice.
    ga_weighted_select #(.ENTRIES(NUM_OPS)) u_sel_op (
        .thr(op_thr_q), .r(lfsr_a_q[7:0]), .idx(sel_op)
    );
    ga_weighted_select #(.ENTRIES(OPERAND_BINS)) u_sel_a (
        .thr(a_thr_q), .r(lfsr_a_q[15:8]), .idx(sel_a)
    );
    ga_weighted_select #(.ENTRIES(OPERAND_BINS)) u_sel_b (
        .thr(b_thr_q), .r(lfsr_a_q[23:16]), .idx(sel_b)
    );
    ga_weighted_select #(.ENTRIES(DELAY_BINS)) u_sel_dly (
        .thr(dly_thr_q), .r(lfsr_a_q[31:24]), .idx(sel_dly)
    );

    function automatic logic [DATA_WIDTH-1:0] shape_operand(
        input logic [1:0]            bin,
        input logic [DATA_WIDTH-1:0] data
    );
        case (bin)
            BIN_ZERO:   return '0;
            BIN_SMALL:  return (data[3:0] == 4'd0) ? DATA_WIDTH'(1) : DATA_WIDTH'(data[3:0]);
            BIN_RANDOM: return data;
            default:    return '1;
        endcase
    endfunction

    // Operand data comes from LFSR B: A takes the low DATA_WIDTH bits, B the
    // next DATA_WIDTH bits, wrapping around the 32-bit register when wide.
    always_comb begin
        data_a = '0;
        data_b = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            data_a[i] = lfsr_b_q[i % 32];
            data_b[i] = lfsr_b_q[(DATA_WIDTH + i) % 32];
        end
    end

    assign sent_cnt_inc = sent_cnt_q + CNT_WIDTH'(1);

    // Next-state logic: table writes while idle, run launch, field generation,
    // handshake/termination and delay countdown. Outputs are registered from
    // the next state so they line up exactly with the state they describe.
    always_comb begin
        state_d     = state_q;
        op_thr_d    = op_thr_q;
        a_thr_d     = a_thr_q;
        b_thr_d     = b_thr_q;
        dly_thr_d   = dly_thr_q;
        lfsr_a_d    = lfsr_a_q;
        lfsr_b_d    = lfsr_b_q;
        trans_num_d = trans_num_q;
        sent_cnt_d  = sent_cnt_q;
        dly_d       = dly_q;
        dly_cnt_d   = dly_cnt_q;
        out_op_d    = out_op_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;

        if (state_q == ST_IDLE && cfg_we) begin
            for (int i = 0; i < NUM_OPS; i++)
                if (int'(cfg_addr) == i) op_thr_d[i*THR_WIDTH +: THR_WIDTH] = cfg_data;
            for (int i = 0; i < OPERAND_BINS; i++) begin
                if (int'(cfg_addr) == A_BASE + i) a_thr_d[i*THR_WIDTH +: THR_WIDTH] = cfg_data;
                if (int'(cfg_addr) == B_BASE + i) b_thr_d[i*THR_WIDTH +: THR_WIDTH] = cfg_data;
            end
            for (int i = 0; i < DELAY_BINS; i++)
                if (int'(cfg_addr) == D_BASE + i) dly_thr_d[i*THR_WIDTH +: THR_WIDTH] = cfg_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sent_cnt_d  = '0;
                    trans_num_d = trans_num;
                    lfsr_a_d    = lfsr_seed(seed);
                    lfsr_b_d    = lfsr_seed(~seed);
                    state_d     = (trans_num != '0) ? ST_GEN : ST_DONE;
                end
            end
            ST_GEN: begin
                out_op_d = sel_op;
                out_a_d  = shape_operand(sel_a, data_a);
                out_b_d  = shape_operand(sel_b, data_b);
                dly_d    = sel_dly;
                lfsr_a_d = lfsr_next(lfsr_a_q);
                lfsr_b_d = lfsr_next(lfsr_b_q);
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    sent_cnt_d = sent_cnt_inc;
                    if (sent_cnt_inc == trans_num_q) begin
                        state_d = ST_DONE;
                    end else if (dly_q == '0) begin
                        state_d = ST_GEN;
                    end else begin
                        dly_cnt_d = dly_q - DLY_W'(1);
                        state_d   = ST_DELAY;
                    end
                end
            end
            ST_DELAY: begin
                if (dly_cnt_q == '0) state_d = ST_GEN;
                else                 dly_cnt_d = dly_cnt_q - DLY_W'(1);
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        out_valid_d = (state_d == ST_HOLD);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    // State register; reset also restores the default all-0xFF chromosome.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_thr_q    <= '1;
            a_thr_q     <= '1;
            b_thr_q     <= '1;
            dly_thr_q   <= '1;
            lfsr_a_q    <= 32'd1;
            lfsr_b_q    <= 32'd1;
            trans_num_q <= '0;
            sent_cnt_q  <= '0;
            dly_q       <= '0;
            dly_cnt_q   <= '0;
            out_op_q    <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_thr_q    <= op_thr_d;
            a_thr_q     <= a_thr_d;
            b_thr_q     <= b_thr_d;
            dly_thr_q   <= dly_thr_d;
            lfsr_a_q    <= lfsr_a_d;
            lfsr_b_q    <= lfsr_b_d;
            trans_num_q <= trans_num_d;
            sent_cnt_q  <= sent_cnt_d;
            dly_q       <= dly_d;
            dly_cnt_q   <= dly_cnt_d;
            out_op_q    <= out_op_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sent_cnt  = sent_cnt_q;

endmodule
